branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Decode-side partner of the fetch stage. Consumes the fetched instruction and PC+1
//  and returns mux_ctrl/jp_address to steer the fetch address register.
//  Holds the IF/ID pipeline register, resolves J/JAL/JR/BEQ/BNE and raises the redirect.
//  Squashes the wrong-path instructions already in flight and produces the JAL link write.
// PARAMETERS
//  ADDR_W        4   instruction address width (word addressed, matches fetch PC)
//  DATA_W        32  instruction / register data width
//  FLUSH_CYCLES  2   captures squashed after a redirect (address reg + 1-cycle RAM read)
// PORTS
//  clk          in   1       system clock, rising edge
//  reset        in   1       asynchronous, active-high
//  if_instr     in   DATA_W  instruction word from instruction RAM (registered read)
//  if_pc4       in   ADDR_W  fetch PC+1, combinational from current fetch address
//  rs_data      in   DATA_W  register-file read data for rs_addr
//  rt_data      in   DATA_W  register-file read data for rt_addr
//  rs_addr      out  5       id_instr[25:21]
//  rt_addr      out  5       id_instr[20:16]
//  mux_ctrl     out  1       1 = fetch loads jp_address at next edge
//  jp_address   out  ADDR_W  redirect target
//  id_instr     out  DATA_W  IF/ID instruction register
//  id_pc4       out  ADDR_W  PC+1 aligned to id_instr
//  id_valid     out  1       id_instr is on the correct path
//  link_we      out  1       write link register ($31) this cycle
//  link_data    out  ADDR_W  value written on link (id_pc4)
// BEHAVIOUR
//  Reset (async): id_instr=0, id_pc4=0, id_valid=0, pc4_d=0, state=RUN, flush_cnt=0.
//   All outputs derived from these are therefore 0.
//  Alignment: if_pc4 is delayed one cycle (pc4_d) so it matches the RAM's registered output.
//   Each edge: id_instr<=if_instr, id_pc4<=pc4_d.
//  Decode (combinational from id_instr; opcode=[31:26], funct=[5:0]):
//   J   op=000010  taken; target=id_instr[ADDR_W-1:0]
//   JAL op=000011  as J; plus link_we=1, link_data=id_pc4
//   JR  op=000000, funct=001000  taken; target=rs_data[ADDR_W-1:0]
//   BEQ op=000100  taken iff rs_data==rt_data; target=id_pc4+imm[ADDR_W-1:0]
//   BNE op=000101  taken iff rs_data!=rt_data; same target as BEQ
//   All other opcodes: not taken.
//   Target addition is truncated to ADDR_W, i.e. wraps modulo 2^ADDR_W.
//  mux_ctrl = taken & id_valid; jp_address = target when mux_ctrl, else 0.
//   link_we is gated by id_valid.
//  FSM:
//   RUN: id_valid<=1 each capture.
//    On mux_ctrl: go to FLUSH with flush_cnt<=FLUSH_CYCLES; id_valid<=0 on this edge.
//   FLUSH: id_valid<=0 on every capture; flush_cnt decrements each edge.
//    When flush_cnt==1 at an edge: state<=RUN and id_valid<=1 for that capture.
//    That capture is the target instruction.
//  mux_ctrl is a single-cycle pulse per taken control instruction.
//   Squashed (id_valid=0) jumps never redirect and never link.
//  Back-to-back jumps: the second is in the squash window, so it is ignored.
//  Reset mid-FLUSH: returns immediately to RUN, flush_cnt=0, no pending redirect.
//  No delay slot is implemented; the wrong-path instructions are squashed.
// STRUCTURE
//  Opcode/funct localparams go in shared include mips_defs.vh:
//   OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, FN_JR.
//  FSM state encodings (ST_RUN, ST_FLUSH) are local to this module.
//  Sub-module branch_target_gen: combinational decode -> {taken, target, is_link}.
//  The top module keeps the IF/ID registers, pc4_d and the FSM.
// TESTING
//  J: id_instr=0x08000009, id_valid=1 -> mux_ctrl=1 and jp_address=9 for exactly 1 cycle.
//   Then id_valid=0 for 2 captures, then the instruction at address 9 arrives with id_valid=1.
//  BEQ: 0x10220003, rs_data=rt_data=0x55, id_pc4=5 -> mux_ctrl=1, jp_address=8.
//   Same instruction with rt_data=0x56 -> mux_ctrl=0, no squash.
//  BNE wrap: 0x1422FFFF, rs_data!=rt_data, id_pc4=14 -> jp_address=13.
//  JAL: 0x0C000004 at id_pc4=3 -> link_we=1, link_data=3, jp_address=4.
//   A second JAL in the next capture is squashed, so link_we stays 0.
//  JR: 0x03E00008, rs_data=0x00000007 -> jp_address=7.
//   Non-jump 0x00221820 (ADD) -> mux_ctrl=0.
//  Reset asserted one cycle into FLUSH -> all outputs 0 immediately.
//   After release: id_valid=1 on the first capture, no redirect issued.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// rtl/branch_resolve_unit_pkg.sv - shared MIPS opcode/funct encodings for the branch resolve slice
package branch_resolve_unit_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] FN_JR    = 6'b001000;

    // Captures to squash after a redirect: fetch address register + registered RAM read.
    localparam int FLUSH_CYCLES_DEFAULT = 2;

endpackage

// File: rtl/branch_resolve_unit_target_gen.sv
// rtl/branch_resolve_unit_target_gen.sv - combinational control-flow decode: taken, target, link
module branch_target_gen
    import branch_resolve_unit_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] instr,
    input  logic [ADDR_W-1:0] pc4,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output logic              taken,
    output logic [ADDR_W-1:0] target,
    output logic              is_link
);

    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [ADDR_W-1:0] br_target;
    logic              rs_eq;
    logic              unused_instr_bits;

    assign opcode    = instr[31:26];
    assign funct     = instr[5:0];
    // Only the low ADDR_W bits of the offset matter: the sum wraps modulo 2^ADDR_W.
    assign br_target = pc4 + instr[ADDR_W-1:0];
    assign rs_eq     = (rs_data == rt_data);
    assign unused_instr_bits = ^instr;

    // Decode the instruction in ID into a redirect decision and its target.
    always_comb begin
        taken   = 1'b0;
        target  = '0;
        is_link = 1'b0;
        case (opcode)
            OP_J: begin
                taken  = 1'b1;
                target = instr[ADDR_W-1:0];
            end
            OP_JAL: begin
                taken   = 1'b1;
                target  = instr[ADDR_W-1:0];
                is_link = 1'b1;
            end
            OP_RTYPE: begin
                if (funct == FN_JR) begin
                    taken  = 1'b1;
                    target = rs_data[ADDR_W-1:0];
                end
            end
            OP_BEQ: begin
                taken  = rs_eq;
                target = br_target;
            end
            OP_BNE: begin
                taken  = !rs_eq;
                target = br_target;
            end
            default: begin
                taken = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - IF/ID register, jump/branch redirect and wrong-path squash
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 32,
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] if_instr,
    input  logic [ADDR_W-1:0] if_pc4,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output logic [4:0]        rs_addr,
    output logic [4:0]        rt_addr,
    output logic              mux_ctrl,
    output logic [ADDR_W-1:0] jp_address,
    output logic [DATA_W-1:0] id_instr,
    output logic [ADDR_W-1:0] id_pc4,
    output logic              id_valid,
    output logic              link_we,
    output logic [ADDR_W-1:0] link_data
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    state_e            state, state_n;
    logic [CNT_W-1:0]  flush_cnt, flush_cnt_n;
    logic              id_valid_n;
    logic [ADDR_W-1:0] pc4_d;
    logic              taken;
    logic [ADDR_W-1:0] target;
    logic              is_link;

    branch_target_gen #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_target_gen (
        .instr   (id_instr),
        .pc4     (id_pc4),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .taken   (taken),
        .target  (target),
        .is_link (is_link)
    );

    assign rs_addr    = id_instr[25:21];
    assign rt_addr    = id_instr[20:16];
    assign mux_ctrl   = taken & id_valid;
    assign jp_address = mux_ctrl ? target : '0;
    assign link_we    = is_link & id_valid;
    assign link_data  = id_pc4;

    // IF/ID capture; PC+1 is delayed once so it lines up with the RAM's registered output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc4_d    <= '0;
            id_instr <= '0;
            id_pc4   <= '0;
        end else begin
            pc4_d    <= if_pc4;
            id_instr <= if_instr;
            id_pc4   <= pc4_d;
        end
    end

    // Squash FSM state, flush counter and the validity of each capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_RUN;
            flush_cnt <= '0;
            id_valid  <= 1'b0;
        end else begin
            state     <= state_n;
            flush_cnt <= flush_cnt_n;
            id_valid  <= id_valid_n;
        end
    end

    // Next-state: a redirect opens the squash window; its last edge captures the target.
    always_comb begin
        state_n     = state;
        flush_cnt_n = flush_cnt;
        id_valid_n  = 1'b1;
        case (state)
            ST_RUN: begin
                if (mux_ctrl) begin
                    state_n     = ST_FLUSH;
                    flush_cnt_n = CNT_W'(FLUSH_CYCLES);
                    id_valid_n  = 1'b0;
                end
            end
            ST_FLUSH: begin
                flush_cnt_n = flush_cnt - CNT_W'(1);
                if (flush_cnt == CNT_W'(1)) begin
                    state_n    = ST_RUN;
                    id_valid_n = 1'b1;
                end else begin
                    id_valid_n = 1'b0;
                end
            end
            default: begin
                state_n     = ST_RUN;
                flush_cnt_n = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;

    localparam logic [31:0] NOP   = 32'h0000_0000;
    localparam logic [31:0] I_J   = 32'h0800_0009;
    localparam logic [31:0] I_BEQ = 32'h1022_0003;
    localparam logic [31:0] I_BNE = 32'h1422_FFFF;
    localparam logic [31:0] I_JAL = 32'h0C00_0004;
    localparam logic [31:0] I_JR  = 32'h03E0_0008;
    localparam logic [31:0] I_ADD = 32'h0022_1820;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_instr;
    logic [3:0]  if_pc4;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        mux_ctrl;
    logic [3:0]  jp_address;
    logic [31:0] id_instr;
    logic [3:0]  id_pc4;
    logic        id_valid;
    logic        link_we;
    logic [3:0]  link_data;

    int total = 0;
    int bad   = 0;

    branch_resolve_unit #(
        .ADDR_W       (4),
        .DATA_W       (32),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .if_instr   (if_instr),
        .if_pc4     (if_pc4),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .mux_ctrl   (mux_ctrl),
        .jp_address (jp_address),
        .id_instr   (id_instr),
        .id_pc4     (id_pc4),
        .id_valid   (id_valid),
        .link_we    (link_we),
        .link_data  (link_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Places instr in ID with id_pc4 == pc4 (PC+1 lags the instruction by one edge).
    task automatic load(input logic [31:0] instr, input logic [3:0] pc4);
        if_pc4   = pc4;
        if_instr = NOP;
        tick();
        if_instr = instr;
        tick();
    endtask

    initial begin
        reset    = 1'b1;
        if_instr = NOP;
        if_pc4   = 4'd0;
        rs_data  = 32'd0;
        rt_data  = 32'd0;
        #2;
        chk("rst_id_instr", id_instr, 32'h0);
        chk("rst_id_pc4", {28'd0, id_pc4}, 32'h0);
        chk("rst_id_valid", {31'd0, id_valid}, 32'h0);
        chk("rst_mux_ctrl", {31'd0, mux_ctrl}, 32'h0);
        chk("rst_jp_address", {28'd0, jp_address}, 32'h0);
        chk("rst_link_we", {31'd0, link_we}, 32'h0);
        tick();
        reset = 1'b0;

        // J: one-cycle redirect, two squashed captures, then the target instruction
        load(I_J, 4'd2);
        chk("j_valid", {31'd0, id_valid}, 32'h1);
        chk("j_mux", {31'd0, mux_ctrl}, 32'h1);
        chk("j_addr", {28'd0, jp_address}, 32'h9);
        if_instr = I_JAL;
        tick();
        chk("j_sq1_valid", {31'd0, id_valid}, 32'h0);
        chk("j_sq1_mux", {31'd0, mux_ctrl}, 32'h0);
        chk("j_sq1_link", {31'd0, link_we}, 32'h0);
        if_instr = I_BEQ;
        tick();
        chk("j_sq2_valid", {31'd0, id_valid}, 32'h0);
        chk("j_sq2_mux", {31'd0, mux_ctrl}, 32'h0);
        if_instr = I_ADD;
        tick();
        chk("j_tgt_valid", {31'd0, id_valid}, 32'h1);
        chk("j_tgt_instr", id_instr, I_ADD);
        chk("j_tgt_mux", {31'd0, mux_ctrl}, 32'h0);

        // BEQ taken
        rs_data = 32'h55;
        rt_data = 32'h55;
        load(I_BEQ, 4'd5);
        chk("beq_rs_addr", {27'd0, rs_addr}, 32'd1);
        chk("beq_rt_addr", {27'd0, rt_addr}, 32'd2);
        chk("beq_pc4", {28'd0, id_pc4}, 32'd5);
        chk("beq_mux", {31'd0, mux_ctrl}, 32'h1);
        chk("beq_addr", {28'd0, jp_address}, 32'h8);
        if_instr = NOP;
        tick();
        chk("beq_pulse", {31'd0, mux_ctrl}, 32'h0);

        // BEQ not taken: no redirect and no squash
        rt_data = 32'h56;
        load(I_BEQ, 4'd5);
        chk("beqn_mux", {31'd0, mux_ctrl}, 32'h0);
        chk("beqn_addr", {28'd0, jp_address}, 32'h0);
        chk("beqn_valid", {31'd0, id_valid}, 32'h1);
        if_instr = I_ADD;
        tick();
        chk("beqn_nosquash", {31'd0, id_valid}, 32'h1);

        // BNE with a negative offset wrapping modulo 16
        rs_data = 32'h1;
        rt_data = 32'h2;
        load(I_BNE, 4'd14);
        chk("bne_mux", {31'd0, mux_ctrl}, 32'h1);
        chk("bne_addr", {28'd0, jp_address}, 32'd13);
        if_instr = NOP;
        tick();

        // JAL links; a following JAL in the squash window neither links nor redirects
        load(I_JAL, 4'd3);
        chk("jal_link_we", {31'd0, link_we}, 32'h1);
        chk("jal_link_data", {28'd0, link_data}, 32'd3);
        chk("jal_addr", {28'd0, jp_address}, 32'd4);
        if_instr = I_JAL;
        tick();
        chk("jal2_instr", id_instr, I_JAL);
        chk("jal2_link_we", {31'd0, link_we}, 32'h0);
        chk("jal2_mux", {31'd0, mux_ctrl}, 32'h0);
        if_instr = NOP;
        tick();

        // JR through $31
        rs_data = 32'h0000_0007;
        load(I_JR, 4'd4);
        chk("jr_rs_addr", {27'd0, rs_addr}, 32'd31);
        chk("jr_mux", {31'd0, mux_ctrl}, 32'h1);
        chk("jr_addr", {28'd0, jp_address}, 32'd7);
        if_instr = NOP;
        tick();

        // ADD is not a control instruction
        load(I_ADD, 4'd6);
        chk("add_valid", {31'd0, id_valid}, 32'h1);
        chk("add_mux", {31'd0, mux_ctrl}, 32'h0);
        chk("add_link", {31'd0, link_we}, 32'h0);

        // Reset one cycle into FLUSH clears everything at once
        load(I_J, 4'd2);
        chk("rj_mux", {31'd0, mux_ctrl}, 32'h1);
        if_instr = I_J;
        tick();
        reset = 1'b1;
        #1;
        chk("rf_id_instr", id_instr, 32'h0);
        chk("rf_id_valid", {31'd0, id_valid}, 32'h0);
        chk("rf_mux", {31'd0, mux_ctrl}, 32'h0);
        chk("rf_addr", {28'd0, jp_address}, 32'h0);
        chk("rf_link_data", {28'd0, link_data}, 32'h0);
        #2;
        reset    = 1'b0;
        if_instr = I_ADD;
        tick();
        chk("rr_valid", {31'd0, id_valid}, 32'h1);
        chk("rr_instr", id_instr, I_ADD);
        chk("rr_mux", {31'd0, mux_ctrl}, 32'h0);
        tick();
        chk("rr_valid2", {31'd0, id_valid}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
